pulse_capture: RTL and testbench
================================

Name: pulse_capture

Overview:
Input-capture peripheral on the same 2-bit-address CPU register bus as the countdown timer. Where the timer generates time, this block measures it: it timestamps an external input (pulse_in) and reports either the high-pulse width or the rising-to-rising period, in prescaled clock ticks, as a 16-bit value. It raises a level interrupt (irq) when a measurement completes.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on pulse_in (minimum 2)
DIV_RESET, 0, reset value of the prescaler divisor register

Ports:
clk  input  1  system clock; the only clock
rst  input  1  reset, asynchronous, active-high
dbr  output 8  data bus READ (registered)
dbw  input  8  data bus WRITE
addr input  2  register select
we   input  1  1 = write cycle, 0 = read cycle (no separate chip select)
pulse_in input 1  asynchronous external signal under measurement
irq  output 1  level interrupt, equal to done & ie

Behaviour:
- Reset (async, rst high): dbr=0, state=IDLE, count=0, capture=0, hi_latch=0, done=0, ovf=0, arm=0, mode=0, ie=0, div=DIV_RESET, prescale counter=0, synchroniser flops=0.
- Register map, write side (we=1):
  - 0 and 1: ignored.
  - 2 CTRL: arm=dbw[0], mode=dbw[1] (0 = high width rise->fall, 1 = period rise->rise), ie=dbw[6]. Clears done, ovf and count. Next state is WAIT if dbw[0]=1, otherwise IDLE. This write aborts any measurement in progress.
  - 3 DIV: div=dbw.
- Register map, read side (we=0). dbr is updated on the clock edge, giving one-cycle latency:
  - 0: dbr=capture[7:0]; on the same edge hi_latch<=capture[15:8].
  - 1: dbr=hi_latch.
  - 2: dbr={done,ovf,ie,3'b0,mode,arm}.
  - 3: dbr=div.
  - Reading 0 and then 1 always returns a coherent 16-bit value.
- Input path: pulse_in passes through SYNC_STAGES flops, then one delay flop. rise = s & ~s_d; fall = ~s & s_d. Both edges see the same latency, so it cancels in the measurement.
- Prescaler: 8-bit pre counts 0..div and only while in MEASURE. tick=1 when pre==div, and pre then wraps to 0. pre is cleared on entry to MEASURE. div=0 means a tick every clock. A DIV write during MEASURE takes effect at the next compare.
- FSM:
  - IDLE: waits for a CTRL write.
  - WAIT: on rise, go to MEASURE with count<=0 and pre<=0.
  - MEASURE: on tick, count<=count+1. If count==16'hFFFF, count holds and ovf<=1 (saturating).
    - End edge: fall when mode=0, rise when mode=1.
    - On the end edge: capture<=sat(count+tick), done<=1, arm<=0, state<=IDLE.
    - A tick in the same cycle as the end edge is counted.
- Simultaneous events:
  - CTRL write in the same cycle as an end edge: the write wins; no capture, done stays cleared.
  - Capture update in the same cycle as a read of addr 0: dbr and hi_latch take the old capture, consistently.
- Captures are one-shot. A new measurement requires a re-arm. done stays set until the next CTRL write.
- Reset asserted mid-measurement: immediate return to reset values, no partial capture.

Decomposition:
- Shared package: register address constants (REG_CAPL=0, REG_CAPH=1, REG_CTRL=2, REG_DIV=3), CTRL bit positions (ARM=0, MODE=1, IE=6, OVF=6 on read, DONE=7), FSM state encoding (IDLE, WAIT, MEASURE).
- One sub-module, sync_edge: the SYNC_STAGES synchroniser plus delay flop, with outputs level, rise and fall, using the same clk and rst.

Test Plan:
- div=0, CTRL=0x01, pulse_in high for 100 clocks -> done=1, capture=100; read addr0 then addr1 -> 0x64, 0x00; ovf=0.
- div=3, CTRL=0x03 (period), rising edges 400 clocks apart -> capture=100; a third rising edge after done causes no change.
- div=255, CTRL=0x41, pulse_in high for 256*70000 clocks -> capture=0xFFFF, ovf=1, done=1, irq=1; CTRL write 0x00 -> done=0, ovf=0, irq=0.
- Coherency: read addr0 in the same cycle a new capture (0x1234, replacing 0x00FF) lands -> dbr=0xFF; then read addr1 -> 0x00; next addr0/addr1 pair -> 0x34, 0x12.
- Abort: CTRL=0x01, rise, then CTRL=0x01 written 50 clocks later while high -> no capture; measurement restarts on the next rise. Async rst pulse mid-MEASURE -> all registers read 0, dbr=0.

Source files
------------

// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse_capture input-capture peripheral:
// register map, CTRL/status bit positions, FSM encoding and small helpers.
package pulse_capture_pkg;

  localparam logic [1:0] REG_CAPL = 2'd0;
  localparam logic [1:0] REG_CAPH = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IE   = 6;

  localparam int STAT_ARM  = 0;
  localparam int STAT_MODE = 1;
  localparam int STAT_IE   = 5;
  localparam int STAT_OVF  = 6;
  localparam int STAT_DONE = 7;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  // Saturating increment: the counter never wraps past its maximum.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    if (inc && (v != COUNT_MAX)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [7:0] status_byte(input logic done, input logic ovf,
                                             input logic ie, input logic mode,
                                             input logic arm);
    logic [7:0] s;
    s            = 8'd0;
    s[STAT_DONE] = done;
    s[STAT_OVF]  = ovf;
    s[STAT_IE]   = ie;
    s[STAT_MODE] = mode;
    s[STAT_ARM]  = arm;
    return s;
  endfunction

endpackage

// File: rtl/pulse_capture_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a delay flop,
// producing the synchronised level and single-cycle rise/fall strobes.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchroniser chain plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/pulse_capture.sv
// Input-capture peripheral: measures high width or period of pulse_in in
// prescaled ticks, exposed on a 2-bit-address CPU register bus.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DIV_RESET   = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       pulse_in,
  output logic       irq
);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] capture_q;
  logic [7:0]  hi_latch_q;
  logic        done_q;
  logic        ovf_q;
  logic        arm_q;
  logic        mode_q;
  logic        ie_q;
  logic [7:0]  div_q;
  logic [7:0]  pre_q;
  logic [7:0]  dbr_q;

  logic        level_s;
  logic        rise_s;
  logic        fall_s;
  logic        ctrl_wr_s;
  logic        div_wr_s;
  logic        tick_s;
  logic        end_edge_s;
  logic        hit_max_s;
  logic [15:0] count_d;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (pulse_in),
    .level_o(level_s),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Bus decode, prescaler compare and next count value.
  always_comb begin
    ctrl_wr_s = we && (addr == REG_CTRL);
    div_wr_s  = we && (addr == REG_DIV);
    tick_s    = (state_q == ST_MEASURE) && (pre_q == div_q);
    hit_max_s = tick_s && (count_q == COUNT_MAX);
    count_d   = sat_inc(count_q, tick_s);
    if (mode_q) begin
      end_edge_s = rise_s & level_s;
    end else begin
      end_edge_s = fall_s & ~level_s;
    end
  end

  // Measurement FSM with its counters and control/status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= 16'd0;
      capture_q <= 16'd0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      arm_q     <= 1'b0;
      mode_q    <= 1'b0;
      ie_q      <= 1'b0;
      div_q     <= DIV_RESET;
      pre_q     <= 8'd0;
    end else begin
      if (div_wr_s) begin
        div_q <= dbw;
      end
      // A CTRL write overrides anything the FSM would do this cycle.
      if (ctrl_wr_s) begin
        arm_q   <= dbw[CTRL_ARM];
        mode_q  <= dbw[CTRL_MODE];
        ie_q    <= dbw[CTRL_IE];
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
        count_q <= 16'd0;
        state_q <= dbw[CTRL_ARM] ? ST_WAIT : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_WAIT: begin
            if (rise_s) begin
              state_q <= ST_MEASURE;
              count_q <= 16'd0;
              pre_q   <= 8'd0;
            end
          end
          ST_MEASURE: begin
            if (tick_s) begin
              pre_q <= 8'd0;
            end else begin
              pre_q <= pre_q + 8'd1;
            end
            count_q <= count_d;
            if (hit_max_s) begin
              ovf_q <= 1'b1;
            end
            if (end_edge_s) begin
              capture_q <= count_d;
              done_q    <= 1'b1;
              arm_q     <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Registered read port; the high byte is latched with the low byte read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbr_q      <= 8'd0;
      hi_latch_q <= 8'd0;
    end else if (!we) begin
      case (addr)
        REG_CAPL: begin
          dbr_q      <= capture_q[7:0];
          hi_latch_q <= capture_q[15:8];
        end
        REG_CAPH: dbr_q <= hi_latch_q;
        REG_CTRL: dbr_q <= status_byte(done_q, ovf_q, ie_q, mode_q, arm_q);
        REG_DIV:  dbr_q <= div_q;
        default:  dbr_q <= 8'd0;
      endcase
    end
  end

  assign dbr = dbr_q;
  assign irq = done_q & ie_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: register table, then directed
// multi-cycle measurement sequences, with read results checked via a queue.
module tb_pulse_capture;

  localparam logic [1:0] A_CAPL = 2'd0;
  localparam logic [1:0] A_CAPH = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [1:0] addr;
  logic       we;
  logic       pulse_in;
  logic       irq;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    string      name;
  } vec_t;

  pulse_capture dut (
    .clk     (clk),
    .rst     (rst),
    .dbr     (dbr),
    .dbw     (dbw),
    .addr    (addr),
    .we      (we),
    .pulse_in(pulse_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    we   = 1'b0;
    addr = A_CTRL;
    dbw  = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we   = 1'b1;
    addr = a;
    dbw  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    sb_t it;
    sb_q.push_back('{exp: exp, name: name});
    we   = 1'b0;
    addr = a;
    @(negedge clk);
    it = sb_q.pop_front();
    check8(it.name, dbr, it.exp);
    bus_idle();
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, A_CAPL, 8'h00, "rst_capl"};
    vecs[1]  = '{1'b0, A_CAPH, 8'h00, "rst_caph"};
    vecs[2]  = '{1'b0, A_CTRL, 8'h00, "rst_ctrl"};
    vecs[3]  = '{1'b0, A_DIV,  8'h00, "rst_div"};
    vecs[4]  = '{1'b1, A_DIV,  8'h5A, "wr_div"};
    vecs[5]  = '{1'b0, A_DIV,  8'h5A, "rd_div"};
    vecs[6]  = '{1'b1, A_CTRL, 8'h42, "wr_ctrl_mode_ie"};
    vecs[7]  = '{1'b0, A_CTRL, 8'h22, "rd_ctrl_mode_ie"};
    vecs[8]  = '{1'b1, A_CAPL, 8'h77, "wr_addr0_ignored"};
    vecs[9]  = '{1'b1, A_CAPH, 8'h88, "wr_addr1_ignored"};
    vecs[10] = '{1'b0, A_CAPL, 8'h00, "capl_after_ignored_wr"};
    vecs[11] = '{1'b0, A_DIV,  8'h5A, "div_after_ignored_wr"};
    vecs[12] = '{1'b1, A_CTRL, 8'h00, "wr_ctrl_clear"};
    vecs[13] = '{1'b0, A_CTRL, 8'h00, "rd_ctrl_clear"};

    rst      = 1'b1;
    pulse_in = 1'b0;
    bus_idle();
    cycles(3);
    check8("reset_dbr", dbr, 8'h00);
    check8("reset_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;
    cycles(2);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, vecs[i].data, vecs[i].name);
      end
    end

    // High width, div=0, 100 clocks high.
    wr(A_DIV, 8'h00);
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b1;
    cycles(100);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CTRL, 8'h80, "width_status");
    rd(A_CAPL, 8'h64, "width_capl");
    rd(A_CAPH, 8'h00, "width_caph");
    check8("width_irq_ie0", {7'd0, irq}, 8'h00);

    // Period, div=3, rising edges 400 clocks apart.
    wr(A_DIV, 8'h03);
    wr(A_CTRL, 8'h03);
    pulse_in = 1'b1;
    cycles(10);
    pulse_in = 1'b0;
    cycles(390);
    pulse_in = 1'b1;
    cycles(10);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CTRL, 8'h82, "period_status");
    rd(A_CAPL, 8'h64, "period_capl");
    rd(A_CAPH, 8'h00, "period_caph");
    cycles(100);
    pulse_in = 1'b1;
    cycles(10);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CAPL, 8'h64, "period_oneshot_capl");
    rd(A_CTRL, 8'h82, "period_oneshot_status");

    // CTRL write on the same edge as the end edge wins.
    wr(A_DIV, 8'h00);
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b1;
    cycles(10);
    pulse_in = 1'b0;
    cycles(2);
    wr(A_CTRL, 8'h00);
    cycles(3);
    rd(A_CTRL, 8'h00, "wrwins_status");
    rd(A_CAPL, 8'h64, "wrwins_capl");

    // Abort by re-arming mid-measurement, then a fresh measurement.
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b1;
    cycles(50);
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CTRL, 8'h01, "abort_status");
    pulse_in = 1'b1;
    cycles(30);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CTRL, 8'h80, "abort_restart_status");
    rd(A_CAPL, 8'h1E, "abort_restart_capl");
    rd(A_CAPH, 8'h00, "abort_restart_caph");

    // Coherency: read addr0 on the very edge a new capture lands.
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b1;
    cycles(255);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CAPL, 8'hFF, "coh_first_capl");
    rd(A_CAPH, 8'h00, "coh_first_caph");
    wr(A_CTRL, 8'h01);
    pulse_in = 1'b1;
    cycles(4660);
    pulse_in = 1'b0;
    cycles(2);
    rd(A_CAPL, 8'hFF, "coh_same_edge_capl");
    rd(A_CAPH, 8'h00, "coh_same_edge_caph");
    rd(A_CAPL, 8'h34, "coh_new_capl");
    rd(A_CAPH, 8'h12, "coh_new_caph");
    rd(A_CTRL, 8'h80, "coh_status");

    // Saturation with interrupt enabled.
    wr(A_CTRL, 8'h41);
    pulse_in = 1'b1;
    cycles(65540);
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CTRL, 8'hE0, "ovf_status");
    check8("ovf_irq", {7'd0, irq}, 8'h01);
    rd(A_CAPL, 8'hFF, "ovf_capl");
    rd(A_CAPH, 8'hFF, "ovf_caph");
    wr(A_CTRL, 8'h00);
    rd(A_CTRL, 8'h00, "ovf_clear_status");
    check8("ovf_clear_irq", {7'd0, irq}, 8'h00);

    // Asynchronous reset in the middle of a measurement.
    wr(A_DIV, 8'h07);
    wr(A_CTRL, 8'h41);
    pulse_in = 1'b1;
    cycles(20);
    #2;
    rst = 1'b1;
    #1;
    check8("async_rst_dbr", dbr, 8'h00);
    check8("async_rst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst      = 1'b0;
    pulse_in = 1'b0;
    cycles(5);
    rd(A_CAPL, 8'h00, "post_rst_capl");
    rd(A_CAPH, 8'h00, "post_rst_caph");
    rd(A_CTRL, 8'h00, "post_rst_ctrl");
    rd(A_DIV,  8'h00, "post_rst_div");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
